mem_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU's memory port: accepts one read/write request at a time, waits a

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bus between a memory initiator (the CPU memory port) and
//   mem_responder.
//   Request channel : reqValid, reqWrite, reqAddress, reqWriteData -> reqReady
//   Response channel: respValid, respData, respError -> respReady
//   Modports: master = initiator side, slave = responder side.
interface mem_responder_if #(
  parameter int ADDRESS_SIZE = 20,
  parameter int WORD_SIZE    = 64
);
  logic                    reqValid;
  logic                    reqWrite;
  logic [ADDRESS_SIZE-1:0] reqAddress;
  logic [WORD_SIZE-1:0]    reqWriteData;
  logic                    reqReady;
  logic                    respValid;
  logic                    respReady;
  logic [WORD_SIZE-1:0]    respData;
  logic                    respError;

  modport master (
    output reqValid, reqWrite, reqAddress, reqWriteData, respReady,
    input  reqReady, respValid, respData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqWriteData, respReady,
    output reqReady, respValid, respData, respError
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder with programmable wait states, backed by an internal
//   word array. One request in flight at a time; the response is held until the
//   initiator takes it.
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of mem_responder_if (request/response channels)
//   busy   out  request in flight (WAIT or RESP)
//
// state | meaning
// IDLE  | ready for a request (reqReady=1)
// WAIT  | request latched, counting down wait states
// RESP  | response presented (respValid=1) until respReady
module mem_responder #(
  parameter int ADDRESS_SIZE = 20,
  parameter int WORD_SIZE    = 64,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_responder_if.slave     bus,
  output logic               busy
);
  localparam int INDEX_WIDTH      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FULL_INDEX_WIDTH = ADDRESS_SIZE - 2;
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT                   state;
  stateT                   nextState;
  logic                    commit;
  logic [3:0]              waitCount;
  logic                    latchWrite;
  logic [ADDRESS_SIZE-1:0] latchAddress;
  logic [WORD_SIZE-1:0]    latchData;
  logic [WORD_SIZE-1:0]    respDataReg;
  logic                    respErrorReg;

  logic [WORD_SIZE-1:0]    memArray [DEPTH];

  // With zero wait states the commit happens on the accept edge itself, so the
  // request is taken straight from the bus instead of the latch.
  logic                        commitWrite;
  logic [ADDRESS_SIZE-1:0]     commitAddress;
  logic [WORD_SIZE-1:0]        commitData;
  logic [FULL_INDEX_WIDTH-1:0] commitFullIndex;
  logic [INDEX_WIDTH-1:0]      commitIndex;
  logic                        commitError;

  always_comb begin
    commitWrite   = latchWrite;
    commitAddress = latchAddress;
    commitData    = latchData;
    if (state == IDLE) begin
      commitWrite   = bus.reqWrite;
      commitAddress = bus.reqAddress;
      commitData    = bus.reqWriteData;
    end
  end

  // Upper address bits above the array index only feed the range check.
  assign commitFullIndex = commitAddress[ADDRESS_SIZE-1:2];
  assign commitIndex     = commitFullIndex[INDEX_WIDTH-1:0];
  assign commitError     = (commitAddress[1:0] != 2'b00) ||
                           (32'(commitFullIndex) >= 32'(DEPTH));

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reqValid) begin
          if (LATENCY == 0) begin
            nextState = RESP;
            commit    = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCount == 4'd0) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (bus.respReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      waitCount    <= 4'd0;
      latchWrite   <= 1'b0;
      latchAddress <= '0;
      latchData    <= '0;
      respDataReg  <= '0;
      respErrorReg <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.reqValid) begin
        latchWrite   <= bus.reqWrite;
        latchAddress <= bus.reqAddress;
        latchData    <= bus.reqWriteData;
        waitCount    <= WAIT_LOAD;
      end else if (state == WAIT && waitCount != 4'd0) begin
        waitCount <= waitCount - 4'd1;
      end
      if (commit) begin
        respErrorReg <= commitError;
        respDataReg  <= (commitError || commitWrite) ? '0 : memArray[commitIndex];
      end
    end
  end

  // Array is never cleared; reset only blocks a pending write from landing.
  always_ff @(posedge clk) begin
    if (!reset && commit && commitWrite && !commitError) begin
      memArray[commitIndex] <= commitData;
    end
  end

  assign bus.reqReady  = (state == IDLE);
  assign bus.respValid = (state == RESP);
  assign bus.respData  = respDataReg;
  assign bus.respError = respErrorReg;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (2 wait states and 0 wait states) with directed and
//   random requests and compares against an array-based memory model.
module tb_mem_responder;
  localparam int AW    = 20;
  localparam int WW    = 64;
  localparam int DEPTH = 256;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic busyA;
  logic busyB;

  mem_responder_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) busA();
  mem_responder_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) busB();

  mem_responder #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH), .LATENCY(LAT_A)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave), .busy(busyA));
  mem_responder #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH), .LATENCY(0)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave), .busy(busyB));

  int assertCount = 0;
  int failCount   = 0;

  logic [WW-1:0] modelA [DEPTH];
  logic [WW-1:0] modelB [DEPTH];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic isError(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (int'(a[AW-1:2]) >= DEPTH);
  endfunction

  function automatic logic [AW-1:0] randAddr(input int maxWord);
    logic [AW-1:0] a;
    int kind;
    a = AW'($urandom_range(0, maxWord) * 4);
    kind = $urandom_range(0, 9);
    if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
    if (kind == 1) a[AW-1:10] = (AW-10)'($urandom_range(1, 1023));
    return a;
  endfunction

  // One complete transaction on dutA: accept, wait states, hold, consume.
  task automatic accessA(input logic wr, input logic [AW-1:0] addr,
                         input logic [WW-1:0] data, input int hold);
    logic [WW-1:0] expData;
    logic          expErr;
    int            n;
    expErr  = isError(addr);
    expData = (expErr || wr) ? '0 : modelA[int'(addr[AW-1:2])];
    if (!expErr && wr) modelA[int'(addr[AW-1:2])] = data;

    @(negedge clk);
    checkVal("A.reqReadyIdle", busA.reqReady, 1);
    busA.reqValid     = 1'b1;
    busA.reqWrite     = wr;
    busA.reqAddress   = addr;
    busA.reqWriteData = data;
    busA.respReady    = 1'b0;
    @(posedge clk); #1;
    busA.reqValid     = 1'b0;
    busA.reqWrite     = ~wr;
    busA.reqAddress   = AW'($urandom);
    busA.reqWriteData = {$urandom, $urandom};
    busA.respReady    = 1'($urandom_range(0, 1));
    n = 0;
    while (!busA.respValid && n < 20) begin
      checkVal("A.busyWait", busyA, 1);
      checkVal("A.reqReadyWait", busA.reqReady, 0);
      @(posedge clk); #1;
      n++;
    end
    busA.respReady = 1'b0;
    checkVal("A.latency", n, LAT_A);
    if (busA.respValid) begin
      for (int i = 0; i < hold; i++) begin
        checkVal("A.holdData", busA.respData, expData);
        checkVal("A.holdReqReady", busA.reqReady, 0);
        @(posedge clk); #1;
        busA.reqAddress = AW'($urandom);
      end
      checkVal("A.respValid", busA.respValid, 1);
      checkVal("A.respData", busA.respData, expData);
      checkVal("A.respError", busA.respError, expErr);
      @(negedge clk);
      busA.respReady = 1'b1;
      @(posedge clk); #1;
      busA.respReady = 1'b0;
      checkVal("A.consumedValid", busA.respValid, 0);
      checkVal("A.consumedReady", busA.reqReady, 1);
      checkVal("A.consumedBusy", busyA, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          wr;
    logic [WW-1:0] expDataB;
    logic          expErrB;
    logic          willAccept;
    int            lastAccept;
    int            accepts;

    reset = 1'b1;
    busA.reqValid = 1'b0; busA.reqWrite = 1'b0; busA.reqAddress = '0;
    busA.reqWriteData = '0; busA.respReady = 1'b0;
    busB.reqValid = 1'b0; busB.reqWrite = 1'b0; busB.reqAddress = '0;
    busB.reqWriteData = '0; busB.respReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst.A.reqReady", busA.reqReady, 1);
    checkVal("rst.A.respValid", busA.respValid, 0);
    checkVal("rst.A.respData", busA.respData, 0);
    checkVal("rst.A.respError", busA.respError, 0);
    checkVal("rst.A.busy", busyA, 0);
    checkVal("rst.B.reqReady", busB.reqReady, 1);
    checkVal("rst.B.respValid", busB.respValid, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) accessA(1'b1, AW'(i * 4), {$urandom, $urandom}, 0);

    accessA(1'b1, 20'h00010, 64'hDEAD_BEEF_0000_0001, 0);
    accessA(1'b0, 20'h00010, '0, 0);
    accessA(1'b0, 20'h00010, '0, 5);
    accessA(1'b1, 20'h00012, 64'h1234_5678_9ABC_DEF0, 0);
    accessA(1'b0, 20'h00010, '0, 1);
    accessA(1'b0, 20'h00400, '0, 2);

    // Reset in the middle of a write: no commit, outputs back to reset values.
    accessA(1'b0, 20'h00010, '0, 0);
    @(negedge clk);
    busA.reqValid = 1'b1; busA.reqWrite = 1'b1;
    busA.reqAddress = 20'h00020; busA.reqWriteData = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1;
    busA.reqValid = 1'b0;
    checkVal("rstWait.busyBefore", busyA, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkVal("rstWait.reqReady", busA.reqReady, 1);
    checkVal("rstWait.respValid", busA.respValid, 0);
    checkVal("rstWait.busy", busyA, 0);
    checkVal("rstWait.respData", busA.respData, 0);
    checkVal("rstWait.respError", busA.respError, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    accessA(1'b0, 20'h00020, '0, 0);

    for (int i = 0; i < 80; i++) begin
      accessA(1'($urandom_range(0, 1)), randAddr(DEPTH - 1), {$urandom, $urandom},
              $urandom_range(0, 3));
    end

    // Zero-wait-state responder, request held valid and respReady tied high.
    busB.reqValid  = 1'b1;
    busB.respReady = 1'b1;
    lastAccept = -1;
    accepts    = 0;
    expDataB   = '0;
    expErrB    = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      willAccept = busB.reqReady;
      if (willAccept) begin
        if (accepts < 16) begin
          wr = 1'b1;
          addr = AW'(accepts * 4);
        end else begin
          wr = 1'($urandom_range(0, 1));
          addr = randAddr(15);
        end
        data = {$urandom, $urandom};
        expErrB  = isError(addr);
        expDataB = (expErrB || wr) ? '0 : modelB[int'(addr[AW-1:2])];
        if (!expErrB && wr) modelB[int'(addr[AW-1:2])] = data;
        busB.reqWrite = wr; busB.reqAddress = addr; busB.reqWriteData = data;
      end else begin
        busB.reqWrite = 1'($urandom_range(0, 1));
        busB.reqAddress = AW'($urandom);
        busB.reqWriteData = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      if (willAccept) begin
        checkVal("B.respValid", busB.respValid, 1);
        checkVal("B.respData", busB.respData, expDataB);
        checkVal("B.respError", busB.respError, expErrB);
        checkVal("B.busy", busyB, 1);
        if (lastAccept >= 0) checkVal("B.acceptGap", c - lastAccept, 2);
        lastAccept = c;
        accepts++;
      end else begin
        checkVal("B.respValidIdle", busB.respValid, 0);
      end
    end
    checkVal("B.acceptCount", accepts, 40);
    busB.reqValid  = 1'b0;
    busB.respReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
